// File: rtl/iq_energy_accum_pkg.sv
// rtl/iq_energy_accum_pkg.sv - shared widths, state encoding and limits for the I/Q energy accumulator
package iq_energy_accum_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 16;
    localparam int DEF_LEN_W  = 8;

    localparam int DEF_SQ_W   = 2 * DEF_DATA_W;
    localparam int DEF_SUM_W  = 2 * DEF_DATA_W + 1;

    localparam logic [DEF_ACC_W-1:0] ACC_MAX = {DEF_ACC_W{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Width of an adder that can hold either operand plus one carry bit.
    function automatic int add_w(input int a_w, input int b_w);
        return ((a_w > b_w) ? a_w : b_w) + 1;
    endfunction

endpackage

// File: rtl/iq_energy_accum_sq_sum.sv
// rtl/iq_energy_accum_sq_sum.sv - squaring register stage and I^2+Q^2 sum feeding the accumulator
module iq_sq_sum
    import iq_energy_accum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                aclr,
    input  logic                ena,
    input  logic                clear,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_i,
    input  logic [DATA_W-1:0]   in_q,
    output logic                s_valid,
    output logic [2*DATA_W:0]   s
);

    localparam int SQ_W = 2 * DATA_W;

    logic                   v1_q, v1_d;
    logic [SQ_W-1:0]        sq_i_q, sq_i_d;
    logic [SQ_W-1:0]        sq_q_q, sq_q_d;

    logic signed [SQ_W-1:0] ext_i, ext_q;
    logic signed [SQ_W-1:0] prod_i, prod_q;

    // Exact squares: sign-extend to full product width so -2^(DATA_W-1) squares correctly.
    always_comb begin
        ext_i  = {{DATA_W{in_i[DATA_W-1]}}, in_i};
        ext_q  = {{DATA_W{in_q[DATA_W-1]}}, in_q};
        prod_i = ext_i * ext_i;
        prod_q = ext_q * ext_q;
        v1_d   = in_valid & ~clear;
        sq_i_d = in_valid ? $unsigned(prod_i) : sq_i_q;
        sq_q_d = in_valid ? $unsigned(prod_q) : sq_q_q;
    end

    // Stage-1 register; clear only drops the valid, data is don't-care without it.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            v1_q   <= 1'b0;
            sq_i_q <= '0;
            sq_q_q <= '0;
        end else if (ena) begin
            v1_q   <= v1_d;
            sq_i_q <= sq_i_d;
            sq_q_q <= sq_q_d;
        end
    end

    // Stage-2 sum; it is registered by the accumulator in the parent.
    always_comb begin
        s       = {1'b0, sq_i_q} + {1'b0, sq_q_q};
        s_valid = v1_q & ~clear;
    end

endmodule

// File: rtl/iq_energy_accum.sv
// rtl/iq_energy_accum.sv - block energy accumulator producing one saturated radical per block
module iq_energy_accum
    import iq_energy_accum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                clk,
    input  logic                aclr,
    input  logic                ena,
    input  logic                clear,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_i,
    input  logic [DATA_W-1:0]   in_q,
    input  logic [LEN_W-1:0]    blk_len,
    output logic [ACC_W-1:0]    radical,
    output logic                out_valid,
    output logic                sat
);

    localparam int SUM_W = 2 * DATA_W + 1;
    localparam int ADD_W = add_w(ACC_W, SUM_W);
    localparam logic [ACC_W-1:0] SAT_VAL = {ACC_W{1'b1}};

    logic               s_valid;
    logic [SUM_W-1:0]   s;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               sat_r_q, sat_r_d;
    logic [ACC_W-1:0]   radical_q, radical_d;
    logic               sat_q, sat_d;
    logic               out_valid_q, out_valid_d;

    logic [ADD_W-1:0]   sum_w;
    logic               clamp;
    logic [ACC_W-1:0]   acc_next;
    logic               sat_next;
    logic [LEN_W-1:0]   cnt_next;
    logic [LEN_W-1:0]   len_eff;
    logic               opening;

    iq_sq_sum #(
        .DATA_W (DATA_W)
    ) u_sq_sum (
        .clk      (clk),
        .aclr     (aclr),
        .ena      (ena),
        .clear    (clear),
        .in_valid (in_valid),
        .in_i     (in_i),
        .in_q     (in_q),
        .s_valid  (s_valid),
        .s        (s)
    );

    // Block FSM with saturating accumulate; a new block starts from zero in IDLE.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        sat_r_d     = sat_r_q;
        radical_d   = radical_q;
        sat_d       = sat_q;
        out_valid_d = 1'b0;

        opening  = (state_q == IDLE);
        sum_w    = ADD_W'(opening ? '0 : acc_q) + ADD_W'(s);
        clamp    = (sum_w > ADD_W'(SAT_VAL));
        acc_next = clamp ? SAT_VAL : sum_w[ACC_W-1:0];
        sat_next = (opening ? 1'b0 : sat_r_q) | clamp;
        cnt_next = opening ? LEN_W'(1) : cnt_q + LEN_W'(1);
        len_eff  = opening ? ((blk_len == '0) ? LEN_W'(1) : blk_len) : len_q;

        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            sat_r_d = 1'b0;
        end else if (s_valid) begin
            len_d = len_eff;
            if (cnt_next == len_eff) begin
                radical_d   = acc_next;
                sat_d       = sat_next;
                out_valid_d = 1'b1;
                state_d     = IDLE;
                acc_d       = '0;
                cnt_d       = '0;
                sat_r_d     = 1'b0;
            end else begin
                state_d = ACCUM;
                acc_d   = acc_next;
                cnt_d   = cnt_next;
                sat_r_d = sat_next;
            end
        end
    end

    // All state, including the output pulse, freezes while ena is low.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            sat_r_q     <= 1'b0;
            radical_q   <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (ena) begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            sat_r_q     <= sat_r_d;
            radical_q   <= radical_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign radical   = radical_q;
    assign sat       = sat_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_iq_energy_accum.sv
// tb/tb_iq_energy_accum.sv - directed self-checking bench for iq_energy_accum
module tb_iq_energy_accum;

    logic        clk;
    logic        aclr;
    logic        ena;
    logic        clear;
    logic        in_valid;
    logic [7:0]  in_i;
    logic [7:0]  in_q;
    logic [7:0]  blk_len;
    logic [15:0] radical;
    logic        out_valid;
    logic        sat;

    int tests_run;
    int tests_failed;

    iq_energy_accum dut (
        .clk       (clk),
        .aclr      (aclr),
        .ena       (ena),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_i      (in_i),
        .in_q      (in_q),
        .blk_len   (blk_len),
        .radical   (radical),
        .out_valid (out_valid),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input int q);
        in_valid = 1'b1;
        in_i     = 8'(i);
        in_q     = 8'(q);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        cyc();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        aclr     = 1'b1;
        ena      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_i     = '0;
        in_q     = '0;
        blk_len  = 8'd4;
        cyc();
        cyc();
        check("reset_radical", 32'(radical), 0);
        check("reset_valid", 32'(out_valid), 0);
        check("reset_sat", 32'(sat), 0);
        aclr = 1'b0;
        idle();

        // 1: four (3,4) samples -> 100
        blk_len = 8'd4;
        for (int k = 0; k < 4; k++) begin
            drive(3, 4);
            check("t1_no_early_pulse", 32'(out_valid), 0);
        end
        idle();
        check("t1_valid", 32'(out_valid), 1);
        check("t1_radical", 32'(radical), 100);
        check("t1_sat", 32'(sat), 0);
        idle();
        check("t1_pulse_ends", 32'(out_valid), 0);
        check("t1_radical_hold", 32'(radical), 100);

        // 2: three (-128,-128) samples saturate
        blk_len = 8'd3;
        for (int k = 0; k < 3; k++) drive(-128, -128);
        idle();
        check("t2_valid", 32'(out_valid), 1);
        check("t2_radical", 32'(radical), 65535);
        check("t2_sat", 32'(sat), 1);
        idle();
        check("t2_pulse_ends", 32'(out_valid), 0);
        check("t2_sat_hold", 32'(sat), 1);

        // 3: single-sample blocks back to back, blk_len 1 then 0
        for (int pass = 0; pass < 2; pass++) begin
            blk_len = (pass == 0) ? 8'd1 : 8'd0;
            drive(1, 0);
            check("t3_first_not_yet", 32'(out_valid), 0);
            drive(2, 0);
            check("t3_v1", 32'(out_valid), 1);
            check("t3_r1", 32'(radical), 1);
            check("t3_sat1", 32'(sat), 0);
            drive(0, 5);
            check("t3_v4", 32'(out_valid), 1);
            check("t3_r4", 32'(radical), 4);
            idle();
            check("t3_v25", 32'(out_valid), 1);
            check("t3_r25", 32'(radical), 25);
            idle();
            check("t3_end", 32'(out_valid), 0);
        end

        // 4: stall and gap inside a block, output held while stalled
        blk_len = 8'd4;
        drive(1, 1);
        drive(1, 1);
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_i     = 8'd5;
            in_q     = 8'd5;
            cyc();
            check("t4_stall_quiet", 32'(out_valid), 0);
        end
        in_valid = 1'b0;
        ena = 1'b1;
        idle();
        drive(1, 1);
        check("t4_mid", 32'(out_valid), 0);
        drive(1, 1);
        check("t4_mid2", 32'(out_valid), 0);
        idle();
        check("t4_valid", 32'(out_valid), 1);
        check("t4_radical", 32'(radical), 8);
        ena = 1'b0;
        cyc();
        check("t4_hold_valid", 32'(out_valid), 1);
        cyc();
        check("t4_hold_valid2", 32'(out_valid), 1);
        check("t4_hold_radical", 32'(radical), 8);
        ena = 1'b1;
        idle();
        check("t4_single_pulse", 32'(out_valid), 0);

        // 5: clear aborts a partial block, then a clean block of (2,0)
        blk_len = 8'd4;
        drive(2, 0);
        drive(2, 0);
        clear = 1'b1;
        idle();
        clear = 1'b0;
        check("t5_clear_quiet", 32'(out_valid), 0);
        for (int k = 0; k < 4; k++) begin
            drive(2, 0);
            check("t5_no_early_pulse", 32'(out_valid), 0);
        end
        idle();
        check("t5_valid", 32'(out_valid), 1);
        check("t5_radical", 32'(radical), 16);
        idle();
        check("t5_pulse_ends", 32'(out_valid), 0);

        // 5b: clear in the completion cycle suppresses the pulse
        for (int k = 0; k < 4; k++) drive(3, 0);
        clear = 1'b1;
        idle();
        clear = 1'b0;
        check("t5b_no_pulse", 32'(out_valid), 0);
        check("t5b_radical_kept", 32'(radical), 16);
        idle();
        check("t5b_still_none", 32'(out_valid), 0);

        // 6: asynchronous aclr mid-block, then a full block
        blk_len = 8'd4;
        drive(3, 4);
        drive(3, 4);
        #2;
        aclr = 1'b1;
        #1;
        check("t6_async_radical", 32'(radical), 0);
        check("t6_async_valid", 32'(out_valid), 0);
        check("t6_async_sat", 32'(sat), 0);
        cyc();
        aclr = 1'b0;
        idle();
        idle();
        check("t6_no_partial_pulse", 32'(out_valid), 0);
        for (int k = 0; k < 4; k++) drive(3, 4);
        idle();
        check("t6_valid", 32'(out_valid), 1);
        check("t6_radical", 32'(radical), 100);
        check("t6_sat", 32'(sat), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
